pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush/halt sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB).

---
 rtl/pipeline_hazard_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall/flush/halt sequencer for the 5-stage IF/ID/EX/MEM/WB pipeline.
//   Resolves load-use, EX-resolved branch mispredict and stalled memory
//   handshakes. It also runs the halt drain/resume sequence.
//
//   Ports
//     clk, rst_n               clock (rising edge), async active-low reset
//     ID_rs1/ID_rs2            source regs of the instr in ID
//     ID_use_rs1/ID_use_rs2    the instr in ID actually reads that source
//     ID_halt                  the instr in ID is HLT
//     EX_rd, EX_is_load        destination and load flag of the instr in EX
//     EX_mispredict            branch in EX resolved against its prediction
//     mem_req, mem_ready       MEM-stage data-memory handshake
//     resume                   single-cycle pulse that leaves HALTED
//     pc_stall, *_stall        hold PC / pipeline register (combinational)
//     *_flush                  bubble pipeline register (combinational)
//     hlt                      registered; freezes all pipeline registers
//     state                    FSM state for debug: RUN=0 MEM_WAIT=1 DRAIN=2 HALTED=3
//     stall_cycles             stall-cycle counter
//
//   Build option
//     PIPE_PERF_CNT_EN : when defined, stall_cycles counts cycles with
//                        pc_stall=1 outside HALTED and saturates at all-ones.
//                        When undefined, it is tied to zero and no counter is built.
module pipeline_hazard_ctrl #(
  parameter int REG_W        = 5,
  parameter int DRAIN_CYCLES = 3   // 1..15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] ID_rs1,
  input  logic [REG_W-1:0] ID_rs2,
  input  logic             ID_use_rs1,
  input  logic             ID_use_rs2,
  input  logic             ID_halt,
  input  logic [REG_W-1:0] EX_rd,
  input  logic             EX_is_load,
  input  logic             EX_mispredict,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             resume,
  output logic             pc_stall,
  output logic             IF_ID_stall,
  output logic             ID_EX_stall,
  output logic             EX_MEM_stall,
  output logic             MEM_WB_stall,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             EX_MEM_flush,
  output logic             MEM_WB_flush,
  output logic             hlt,
  output logic [1:0]       state,
  output logic [31:0]      stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } state_t;

  state_t     cur, nxt;
  logic [3:0] drain_cnt, drain_nxt;
  logic       mem_wait, load_use;

  assign mem_wait = mem_req & ~mem_ready;

  // A load writing x0 never creates a dependency.
  assign load_use = EX_is_load && (EX_rd != '0) &&
                    ((ID_use_rs1 && (ID_rs1 == EX_rd)) ||
                     (ID_use_rs2 && (ID_rs2 == EX_rd)));

  // Hazard responses are combinational so every pipeline register reacts on
  // the same edge that the hazard is seen.
  always_comb begin
    pc_stall     = 1'b0;
    IF_ID_stall  = 1'b0;
    ID_EX_stall  = 1'b0;
    EX_MEM_stall = 1'b0;
    MEM_WB_stall = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    // The back half of the pipe is only ever cleared by reset.
    EX_MEM_flush = 1'b0;
    MEM_WB_flush = 1'b0;
    nxt          = cur;
    drain_nxt    = drain_cnt;

    if (cur == HALTED || mem_wait) begin
      // Freeze everything; memory waits are not considered while HALTED.
      pc_stall     = 1'b1;
      IF_ID_stall  = 1'b1;
      ID_EX_stall  = 1'b1;
      EX_MEM_stall = 1'b1;
      MEM_WB_stall = 1'b1;
      if (cur == HALTED) begin
        if (resume) nxt = RUN;
      end else if (cur != DRAIN) begin
        nxt = MEM_WAIT;     // a drain in progress keeps its state and count
      end
    end else begin
      unique case (cur)
        MEM_WAIT: nxt = RUN;   // access completed this cycle
        DRAIN: begin
          if (EX_mispredict) begin
            // The HLT that started the drain was on the wrong path.
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
            nxt         = RUN;
            drain_nxt   = '0;
          end else begin
            pc_stall    = 1'b1;
            IF_ID_flush = 1'b1;
            if (drain_cnt == 4'd1) begin
              nxt       = HALTED;
              drain_nxt = '0;
            end else begin
              drain_nxt = drain_cnt - 4'd1;
            end
          end
        end
        default: begin        // RUN
          if (EX_mispredict) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
          end else if (load_use) begin
            pc_stall    = 1'b1;
            IF_ID_stall = 1'b1;
            ID_EX_flush = 1'b1;
          end else if (ID_halt) begin
            nxt       = DRAIN;
            drain_nxt = 4'(DRAIN_CYCLES);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= RUN;
      drain_cnt <= '0;
      hlt       <= 1'b0;
    end else begin
      cur       <= nxt;
      drain_cnt <= drain_nxt;
      hlt       <= (nxt == HALTED);
    end
  end

  assign state = cur;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_q <= '0;
    else if (pc_stall && cur != HALTED && stall_q != 32'hFFFF_FFFF)
      stall_q <= stall_q + 32'd1;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: single-cycle vector table,
// hand-written multi-cycle sequences and randomized traffic against a
// behavioural model of the sequencing rules.
module tb_pipeline_hazard_ctrl;
  localparam int RW = 5;
  localparam int DC = 3;

  // Output vector order: {pc, IF_ID_s, ID_EX_s, EX_MEM_s, MEM_WB_s,
  //                       IF_ID_f, ID_EX_f, EX_MEM_f, MEM_WB_f}
  localparam logic [8:0] O_NONE = 9'b0_0000_0000;
  localparam logic [8:0] O_LU   = 9'b1_1000_0100;
  localparam logic [8:0] O_MP   = 9'b0_0000_1100;
  localparam logic [8:0] O_FRZ  = 9'b1_1111_0000;
  localparam logic [8:0] O_DRN  = 9'b1_0000_1000;

  logic clk, rst_n;
  logic [RW-1:0] ID_rs1, ID_rs2, EX_rd;
  logic ID_use_rs1, ID_use_rs2, ID_halt, EX_is_load, EX_mispredict;
  logic mem_req, mem_ready, resume;
  logic pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_stall;
  logic IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush, hlt;
  logic [1:0] state;
  logic [31:0] stall_cycles;

  pipeline_hazard_ctrl #(.REG_W(RW), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
    .ID_halt(ID_halt), .EX_rd(EX_rd), .EX_is_load(EX_is_load), .EX_mispredict(EX_mispredict),
    .mem_req(mem_req), .mem_ready(mem_ready), .resume(resume),
    .pc_stall(pc_stall), .IF_ID_stall(IF_ID_stall), .ID_EX_stall(ID_EX_stall),
    .EX_MEM_stall(EX_MEM_stall), .MEM_WB_stall(MEM_WB_stall),
    .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
    .EX_MEM_flush(EX_MEM_flush), .MEM_WB_flush(MEM_WB_flush),
    .hlt(hlt), .state(state), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [8:0] outs = {pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_stall,
                     IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush};

  typedef struct {
    logic [RW-1:0] rs1, rs2, rd;
    logic u1, u2, idh, ld, mp, mreq, mrdy, res;
    logic [8:0] exp;   // expected outputs in the cycle applied (from RUN)
    logic [1:0] nst;   // expected state after the edge
  } vec_t;

  int checks = 0;
  int errors = 0;

  // behavioural model
  int     m_state, m_left;
  logic   m_hlt;
  longint m_cnt;

  logic [8:0]  last_outs;
  logic [1:0]  last_state;
  logic        last_hlt;
  logic [31:0] last_cnt;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic vec_t idle();
    vec_t v;
    v = '{rs1:'0, rs2:'0, rd:'0, u1:0, u2:0, idh:0, ld:0, mp:0,
          mreq:0, mrdy:0, res:0, exp:O_NONE, nst:2'd0};
    return v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_left = 0; m_hlt = 1'b0; m_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One cycle: drive, compare against the model, then advance the model.
  task automatic step(input vec_t v);
    logic [8:0] e;
    int ns, nl;
    logic wt, lu;
    longint ec;
    @(negedge clk);
    ID_rs1 = v.rs1; ID_rs2 = v.rs2; EX_rd = v.rd;
    ID_use_rs1 = v.u1; ID_use_rs2 = v.u2; ID_halt = v.idh;
    EX_is_load = v.ld; EX_mispredict = v.mp;
    mem_req = v.mreq; mem_ready = v.mrdy; resume = v.res;
    #1;
    wt = v.mreq && !v.mrdy;
    lu = v.ld && (v.rd != 0) && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
    ns = m_state; nl = m_left; e = O_NONE;
    if (m_state == 3) begin
      e = O_FRZ;
      if (v.res) ns = 0;
    end else if (wt) begin
      e = O_FRZ;
      if (m_state != 2) ns = 1;
    end else if (m_state == 1) begin
      ns = 0;
    end else if (v.mp) begin
      e = O_MP; ns = 0; nl = 0;
    end else if (m_state == 2) begin
      e = O_DRN; nl = m_left - 1;
      ns = (nl == 0) ? 3 : 2;
    end else if (lu) begin
      e = O_LU;
    end else if (v.idh) begin
      ns = 2; nl = DC;
    end
`ifdef PIPE_PERF_CNT_EN
    ec = m_cnt;
`else
    ec = 0;
`endif
    last_outs = outs; last_state = state; last_hlt = hlt; last_cnt = stall_cycles;
    chk("outs", {23'd0, outs}, {23'd0, e});
    chk("state", {30'd0, state}, m_state);
    chk("hlt", {31'd0, hlt}, {31'd0, m_hlt});
    chk("stall_cycles", stall_cycles, ec[31:0]);
    if (e[8] && m_state != 3) m_cnt++;
    m_state = ns; m_left = nl; m_hlt = (ns == 3);
  endtask

  vec_t tbl[13];
  vec_t v;

  initial begin
    rst_n = 1'b0;
    ID_rs1 = '0; ID_rs2 = '0; EX_rd = '0;
    ID_use_rs1 = 0; ID_use_rs2 = 0; ID_halt = 0; EX_is_load = 0; EX_mispredict = 0;
    mem_req = 0; mem_ready = 0; resume = 0;
    model_reset();

    //          rs1 rs2 rd  u1 u2 idh ld mp mreq mrdy res exp     nst
    tbl[0]  = '{5,  0,  5,  1, 0, 0,  1, 0, 0,   0,   0,  O_LU,   0};
    tbl[1]  = '{0,  0,  0,  1, 1, 0,  1, 0, 0,   0,   0,  O_NONE, 0};
    tbl[2]  = '{1,  7,  7,  1, 1, 0,  1, 0, 0,   0,   0,  O_LU,   0};
    tbl[3]  = '{1,  7,  7,  1, 0, 0,  1, 0, 0,   0,   0,  O_NONE, 0};
    tbl[4]  = '{9,  0,  9,  1, 0, 0,  0, 0, 0,   0,   0,  O_NONE, 0};
    tbl[5]  = '{5,  0,  5,  1, 0, 0,  1, 1, 0,   0,   0,  O_MP,   0};
    tbl[6]  = '{0,  0,  0,  0, 0, 1,  0, 1, 0,   0,   0,  O_MP,   0};
    tbl[7]  = '{0,  0,  0,  0, 0, 1,  0, 0, 0,   0,   0,  O_NONE, 2};
    tbl[8]  = '{0,  0,  0,  0, 0, 0,  0, 0, 1,   0,   0,  O_FRZ,  1};
    tbl[9]  = '{3,  0,  3,  1, 0, 1,  1, 1, 1,   0,   0,  O_FRZ,  1};
    tbl[10] = '{3,  0,  3,  1, 0, 0,  1, 0, 1,   1,   0,  O_LU,   0};
    tbl[11] = '{4,  0,  4,  1, 0, 1,  1, 0, 0,   0,   0,  O_LU,   0};
    tbl[12] = '{0,  0,  0,  0, 0, 0,  0, 0, 0,   1,   1,  O_NONE, 0};

    do_reset();
    step(idle());
    chk("reset_state", {30'd0, last_state}, 32'd0);
    chk("reset_hlt", {31'd0, last_hlt}, 32'd0);
    chk("reset_cnt", last_cnt, 32'd0);

    for (int i = 0; i < 13; i++) begin
      do_reset();
      step(tbl[i]);
      chk($sformatf("tbl%0d_outs", i), {23'd0, last_outs}, {23'd0, tbl[i].exp});
      step(idle());
      chk($sformatf("tbl%0d_next", i), {30'd0, last_state}, {30'd0, tbl[i].nst});
    end

    // load-use clears once the load moves on
    do_reset();
    step(tbl[0]);
    step(idle());
    chk("lu_one_cycle", {23'd0, last_outs}, {23'd0, O_NONE});

    // 4-cycle mem wait then ready
    do_reset();
    v = idle(); v.mreq = 1;
    for (int i = 0; i < 4; i++) begin
      step(v);
      chk("mw_outs", {23'd0, last_outs}, {23'd0, O_FRZ});
    end
    chk("mw_state", {30'd0, last_state}, 32'd1);
    v.mrdy = 1;
    step(v);
    chk("mw_release", {23'd0, last_outs}, {23'd0, O_NONE});
    step(idle());
    chk("mw_back_run", {30'd0, last_state}, 32'd0);

    // halt drain and resume
    do_reset();
    v = idle(); v.idh = 1;
    step(v);
    for (int i = 0; i < DC; i++) begin
      step(idle());
      chk("drain_state", {30'd0, last_state}, 32'd2);
      chk("drain_hlt", {31'd0, last_hlt}, 32'd0);
    end
    v = idle(); v.res = 1;
    step(v);
    chk("halted_state", {30'd0, last_state}, 32'd3);
    chk("halted_hlt", {31'd0, last_hlt}, 32'd1);
    step(idle());
    chk("resume_state", {30'd0, last_state}, 32'd0);
    chk("resume_hlt", {31'd0, last_hlt}, 32'd0);

    // halt with a 2-cycle mem wait inside the drain: hlt 5 cycles later
    do_reset();
    v = idle(); v.idh = 1;
    step(v);
    for (int i = 1; i <= 6; i++) begin
      v = idle();
      if (i == 2 || i == 3) v.mreq = 1;
      step(v);
      chk($sformatf("drainwait_hlt_c%0d", i), {31'd0, last_hlt}, (i == 6) ? 32'd1 : 32'd0);
    end

    // reset mid-drain takes effect immediately
    do_reset();
    v = idle(); v.idh = 1;
    step(v);
    step(idle());
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_drain_state", {30'd0, state}, 32'd0);
    chk("rst_mid_drain_hlt", {31'd0, hlt}, 32'd0);
    rst_n = 1'b1;
    model_reset();

    // stall counter: 4 wait cycles + 1 load-use
    do_reset();
    v = idle(); v.mreq = 1;
    for (int i = 0; i < 4; i++) step(v);
    v.mrdy = 1;
    step(v);
    step(tbl[0]);
    step(idle());
`ifdef PIPE_PERF_CNT_EN
    chk("perf_cnt", last_cnt, 32'd5);
`else
    chk("perf_cnt", last_cnt, 32'd0);
`endif

    // randomized traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      v = idle();
      v.rs1  = RW'($urandom_range(0, 3));
      v.rs2  = RW'($urandom_range(0, 3));
      v.rd   = RW'($urandom_range(0, 3));
      v.u1   = ($urandom_range(0, 1) == 1);
      v.u2   = ($urandom_range(0, 1) == 1);
      v.ld   = ($urandom_range(0, 2) == 0);
      v.idh  = ($urandom_range(0, 7) == 0);
      v.mp   = ($urandom_range(0, 9) == 0);
      v.mreq = ($urandom_range(0, 3) == 0);
      v.mrdy = ($urandom_range(0, 1) == 1);
      v.res  = ($urandom_range(0, 3) == 0);
      step(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
